// File: rtl/stepmotor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stepmotor_ctrl
// Description : 4-coil unipolar stepper controller with programmable period,
//               direction, full/half-step modes, bounded/continuous runs.
// Revision    : 1.0 - initial release
// ============================================================================
module stepmotor_ctrl #(
    parameter int DIV_W = 24,
    parameter int CNT_W = 16,
    parameter bit HOLD  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             half_step,
    input  logic [DIV_W-1:0] period,
    input  logic [CNT_W-1:0] steps,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_pos
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] c_PERIOD_MIN = DIV_W'(2);

    state_t           r_state, w_state;
    logic [2:0]       r_idx, w_idx;
    logic             r_en, w_en;
    logic             r_dir, w_dir;
    logic             r_half, w_half;
    logic [DIV_W-1:0] r_period, w_period;
    logic [CNT_W-1:0] r_steps, w_steps;
    logic [DIV_W-1:0] r_div, w_div;
    logic [CNT_W-1:0] r_pos, w_pos;
    logic             r_done, w_done;
    logic [3:0]       r_coil;

    logic [2:0]       w_adv;
    logic [2:0]       w_idx_step;
    logic             w_last;
    logic [CNT_W-1:0] w_pos_inc;

    function automatic logic [3:0] f_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    f_pattern = 4'b1000;
            3'd1:    f_pattern = 4'b1100;
            3'd2:    f_pattern = 4'b0100;
            3'd3:    f_pattern = 4'b0110;
            3'd4:    f_pattern = 4'b0010;
            3'd5:    f_pattern = 4'b0011;
            3'd6:    f_pattern = 4'b0001;
            default: f_pattern = 4'b1001;
        endcase
    endfunction

    // Full-step from an even index moves by one to realign onto the odd entries.
    assign w_adv      = (!r_half && r_idx[0]) ? 3'd2 : 3'd1;
    assign w_idx_step = r_dir ? (r_idx + w_adv) : (r_idx - w_adv);
    assign w_last     = (r_div == (r_period - DIV_W'(1)));
    assign w_pos_inc  = r_pos + CNT_W'(1);

    always_comb begin
        w_state  = r_state;
        w_idx    = r_idx;
        w_en     = r_en;
        w_dir    = r_dir;
        w_half   = r_half;
        w_period = r_period;
        w_steps  = r_steps;
        w_div    = r_div;
        w_pos    = r_pos;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!HOLD) begin
                    w_en = 1'b0;
                end
                if (start && !stop) begin
                    w_state  = S_RUN;
                    w_dir    = dir;
                    w_half   = half_step;
                    w_period = (period < c_PERIOD_MIN) ? c_PERIOD_MIN : period;
                    w_steps  = steps;
                    w_pos    = '0;
                    w_div    = '0;
                    w_en     = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state = S_IDLE;
                end else if (w_last) begin
                    w_div = '0;
                    w_pos = w_pos_inc;
                    w_idx = w_idx_step;
                    if ((r_steps != '0) && (w_pos_inc == r_steps)) begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 3'd0;
            r_en     <= 1'b0;
            r_dir    <= 1'b0;
            r_half   <= 1'b0;
            r_period <= c_PERIOD_MIN;
            r_steps  <= '0;
            r_div    <= '0;
            r_pos    <= '0;
            r_done   <= 1'b0;
            r_coil   <= 4'b0000;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_en     <= w_en;
            r_dir    <= w_dir;
            r_half   <= w_half;
            r_period <= w_period;
            r_steps  <= w_steps;
            r_div    <= w_div;
            r_pos    <= w_pos;
            r_done   <= w_done;
            r_coil   <= w_en ? f_pattern(w_idx) : 4'b0000;
        end
    end

    assign coil     = r_coil;
    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign step_pos = r_pos;

endmodule
`default_nettype wire

// File: doc/stepmotor_ctrl.md
Name: stepmotor_ctrl

Overview:
Parametrised 4-coil unipolar stepper controller. It is the successor to the fixed-rate board demo and adds:
- programmable step period
- direction control
- full/half-step modes
- bounded or continuous step count
- abort, busy/done status and a live position counter

It sits between board-level controls (switches, keys, a UART register bank) and the ULN2003-type coil driver pins.

Parameters:
DIV_W, 24, width of the period input and the internal divider counter.
CNT_W, 16, width of the steps input and the step_pos counter.
HOLD, 1, coil state in IDLE after a run: 1 = keep last pattern energised (holding torque), 0 = drive 4'b0000.

Ports:
clk  in  1  system clock (50 MHz on board)
rst  in  1  asynchronous, active-low reset
start  in  1  level sampled each clk; in IDLE a 1 latches dir/half_step/period/steps and begins a run
stop  in  1  abort request; ends a run at the next edge
dir  in  1  1 = forward (table index +), 0 = reverse (index −)
half_step  in  1  1 = 8-state half-step, 0 = 4-state two-phase full-step
period  in  DIV_W  clk cycles per step; values 0 and 1 are treated as 2
steps  in  CNT_W  steps to execute; 0 = run continuously until stop
coil  out  4  {A,B,A',B'} drive, active-high
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when a bounded run completes
step_pos  out  CNT_W  steps taken in the current or last run

Behaviour:
- Reset (async, rst=0):
  - state = IDLE; phase index idx = 0; energised flag = 0
  - coil = 0000, busy = 0, done = 0, step_pos = 0, divider = 0
- Half-step table, indexed by idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Full-step mode uses only the odd entries (1100, 0110, 0011, 1001).
- Output and indexing:
  - coil = table[idx] when energised = 1; otherwise coil = 0000.
  - Output is registered, with no combinational path from any input to coil.
- FSM states: IDLE, RUN.
- IDLE → RUN when start=1 and stop=0. At that edge:
  - dir, half_step and the clamped period are latched; steps is latched
  - step_pos ← 0, divider ← 0, energised ← 1, busy ← 1
- In IDLE, start and stop both high: stop wins and the run does not begin.
- RUN:
  - The divider counts 0..P−1, where P is the latched period.
  - When divider = P−1, a step fires: divider ← 0, step_pos ← step_pos+1, and idx is updated mod 8 as follows.
  - Half-step: idx ± 1.
  - Full-step with idx odd: idx ± 2.
  - Full-step with idx even (after a half-step run): idx ± 1, which aligns idx to an odd entry; this counts as a step.
  - First coil change is P cycles after the accepting edge; subsequent changes every P cycles.
  - Inputs other than stop are ignored while in RUN; start is ignored.
- Bounded completion (latched steps ≠ 0): on the edge where step_pos becomes equal to steps:
  - state ← IDLE, busy ← 0, done ← 1 for exactly one cycle
  - the final coil pattern appears on that same edge
- Continuous mode (steps = 0): never self-terminates; step_pos wraps from 2^CNT_W−1 to 0.
- stop in RUN:
  - state ← IDLE and busy ← 0 at the next edge; done stays 0
  - step_pos and idx hold; a step due on that same edge does not fire
- IDLE coil behaviour:
  - HOLD=1: energised stays 1, so coil keeps the last pattern.
  - HOLD=0: energised ← 0 on entry to IDLE, so coil = 0000.
- idx persists across runs; it is not reset on start, so position is continuous across direction and mode changes.
- Reset mid-run:
  - immediate return to reset values; coil = 0000
  - no done pulse, including when a step coincides with reset release

Test Plan:
1. Bounded forward full-step: reset, HOLD=1, period=4, steps=4, dir=1, half_step=0, start pulse.
   - idx 0→1→3→5→7; coil 1100, 0110, 0011, 1001 at 4-cycle spacing
   - done is one pulse coincident with the step_pos=4 edge; busy low after
   - coil holds 1001
2. Reverse half-step, from the end state of test 1: dir=0, half_step=1, period=2, steps=3.
   - coil 0001, 0011, 0010 every 2 cycles; step_pos=3; one done pulse
3. Continuous with abort: steps=0, period=3, start.
   - After 10 steps assert stop one cycle before the 11th step edge: busy drops, step_pos=10, done never asserts, coil frozen.
4. Clamping and priority:
   - period=0 → steps every 2 cycles
   - start and stop asserted together in IDLE → busy stays 0, coil unchanged
   - start held high during RUN → no restart; step_pos not cleared
5. HOLD=0 instance: run steps=2.
   - coil energised only during RUN; 0000 on the cycle after done
6. Async reset mid-run: drop rst between clk edges at step_pos=5.
   - coil=0000, busy=0 and step_pos=0 immediately, without waiting for a clk edge
   - release rst → stays IDLE until the next start
